nios_system_timed_out_pio: RTL and testbench
============================================

NIOS_SYSTEM_TIMED_OUT_PIO -- requirements
Module: nios_system_timed_out_pio

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, output port width (1..32).
REQ-002 The block SHALL have parameter TIMER_WIDTH, default 24, auto-off counter width (1..32).
REQ-003 The block SHALL have parameter PRESCALE, default 1000, clk cycles per timer tick (>=1).
REQ-004 The block SHALL have parameter RESET_VALUE, default 0, DATA_WIDTH-bit reset value of the output register.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port address, input, 3, register select.
REQ-008 The block SHALL have port chipselect, input, 1, slave select.
REQ-009 The block SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32, write data.
REQ-011 The block SHALL have port readdata, output, 32, read data, zero latency (combinational from address).
REQ-012 The block SHALL have port out_port, output, DATA_WIDTH, registered output value.
REQ-013 The block SHALL have port irq, output, 1, high while EXPIRED=1 and IRQ_EN=1.

Function
REQ-014 The block SHALL treat a write as chipselect=1 and write_n=0 in a clk cycle; there SHALL be no wait states.
REQ-015 The block SHALL decode addr0 DATA (R/W): a write loads out_port with writedata[DATA_WIDTH-1:0].
REQ-016 The block SHALL decode addr1 SET (WO, reads 0): a write sets out_port bits where writedata=1.
REQ-017 The block SHALL decode addr2 CLEAR (WO, reads 0): a write clears out_port bits where writedata=1.
REQ-018 The block SHALL decode addr3 TIMEOUT (R/W, TIMER_WIDTH bits): the reload value; 0 disables auto-off.
REQ-019 The block SHALL decode addr4 AUTOMASK (R/W, DATA_WIDTH bits): bits forced to 0 on expiry.
REQ-020 The block SHALL decode addr5 STATUS: bit0 RUNNING (RO, counter!=0), bit1 EXPIRED (sticky, write 1 clears), bit2 IRQ_EN (R/W).
REQ-021 The block SHALL decode addr6 COUNT (RO): the current counter value; addr7 and unused bits SHALL read 0, and writes to them SHALL be ignored.
REQ-022 The block SHALL reload the counter with TIMEOUT and the prescaler with PRESCALE-1 on any write to DATA, SET or CLEAR (a "kick").
REQ-023 The prescaler SHALL decrement every cycle while the counter is nonzero and SHALL issue a one-cycle tick, then reload, when it reaches 0.
REQ-024 The counter SHALL decrement by 1 on each tick and SHALL hold at 0 without wrapping.
REQ-025 When the counter decrements 1->0, the block SHALL, in the same edge, set out_port <= out_port & ~AUTOMASK and set EXPIRED to 1.
REQ-026 A write to TIMEOUT SHALL NOT restart the counter, except that writing 0 SHALL force the counter to 0 with no expiry.
REQ-027 If a kick and an expiry occur in the same cycle, the kick SHALL win: the written value is applied, the counter is reloaded, and EXPIRED is unchanged.
REQ-028 If an EXPIRED-clear write and an expiry occur in the same cycle, EXPIRED SHALL be set.
REQ-029 If SET and CLEAR target the same bit, each SHALL take effect in its own write cycle; there SHALL be no merging across cycles.
REQ-030 With PRESCALE=1, a tick SHALL occur every cycle, giving expiry exactly TIMEOUT cycles after the kick edge.
REQ-031 In general, expiry SHALL occur TIMEOUT*PRESCALE cycles after the kick edge.

Reset
REQ-032 While reset_n=0 at a clk edge, the block SHALL set: out_port=RESET_VALUE, TIMEOUT=0, AUTOMASK=0, counter=0, prescaler=0, EXPIRED=0, IRQ_EN=0, irq=0.
REQ-033 readdata SHALL remain a combinational function of the (reset) registers.
REQ-034 Reset asserted mid-count SHALL abort the count with no expiry and no out_port change beyond the reset value.
REQ-035 The block SHALL NOT react asynchronously to reset_n.

Verification
REQ-036 Bench: reset, then write DATA=0xA5 -> out_port=0xA5 next cycle; read addr0=0x000000A5; read addr1=0.
REQ-037 Bench: DATA=0x0F, SET 0xF0, then CLEAR 0x81 -> out_port 0xFF then 0x7E.
REQ-038 Bench: PRESCALE=1, TIMEOUT=5, AUTOMASK=0x01, IRQ_EN=1, DATA=0x03 -> out_port=0x02 and irq=1 exactly 5 cycles after the DATA edge; COUNT reads 4,3,2,1,0.
REQ-039 Bench: as REQ-038, with a SET 0x00 written in the expiry cycle -> out_port stays 0x03, counter=5, EXPIRED=0.
REQ-040 Bench: write TIMEOUT=0 mid-count -> RUNNING=0, no expiry; write STATUS 0x2 concurrent with expiry -> EXPIRED=1.
REQ-041 Bench: assert reset_n=0 for 1 cycle at count=2 -> out_port=RESET_VALUE, COUNT=0, irq=0, with no later expiry.

Source files
------------

// File: rtl/nios_system_timed_out_pio.sv
// nios_system_timed_out_pio
//
// Memory-mapped output port with an auto-off watchdog. Software drives
// out_port through DATA/SET/CLEAR writes. Each such write ("kick") reloads
// a tick counter. When the counter runs down to zero, the bits selected by
// AUTOMASK are forced low, and a sticky EXPIRED flag is raised. EXPIRED can
// optionally drive irq.
//
// Register map (word address):
//   0 DATA     R/W  output value
//   1 SET      WO   set out_port bits where writedata=1 (reads 0)
//   2 CLEAR    WO   clear out_port bits where writedata=1 (reads 0)
//   3 TIMEOUT  R/W  counter reload value, 0 disables auto-off
//   4 AUTOMASK R/W  bits forced low on expiry
//   5 STATUS   bit0 RUNNING (RO), bit1 EXPIRED (W1C), bit2 IRQ_EN (R/W)
//   6 COUNT    RO   current counter value
//   7 --       reads 0, writes ignored
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data
//   out_port   registered output value
//   irq        EXPIRED & IRQ_EN
module nios_system_timed_out_pio #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    TIMER_WIDTH = 24,
  parameter int                    PRESCALE    = 1000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  // The prescaler only needs to hold PRESCALE-1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);

  logic [DATA_WIDTH-1:0]  data_reg;
  logic [DATA_WIDTH-1:0]  automask;
  logic [TIMER_WIDTH-1:0] timeout;
  logic [TIMER_WIDTH-1:0] count;
  logic [PW-1:0]          presc;
  logic                   expired;
  logic                   irq_en;

  logic wr, wr_data, wr_set, wr_clear, wr_timeout, wr_automask, wr_status;
  logic kick, timeout_zero, running, tick, expire;
  logic unused_bits;

  assign wr          = chipselect && !write_n;
  assign wr_data     = wr && (address == 3'd0);
  assign wr_set      = wr && (address == 3'd1);
  assign wr_clear    = wr && (address == 3'd2);
  assign wr_timeout  = wr && (address == 3'd3);
  assign wr_automask = wr && (address == 3'd4);
  assign wr_status   = wr && (address == 3'd5);

  assign kick         = wr_data || wr_set || wr_clear;
  assign timeout_zero = wr_timeout && (writedata[TIMER_WIDTH-1:0] == '0);
  assign running      = (count != '0);
  assign tick         = running && (presc == '0);

  // A kick or a forced stop in the same cycle suppresses the expiry.
  assign expire = tick && (count == TIMER_WIDTH'(1)) && !kick && !timeout_zero;

  assign irq = expired && irq_en;

  // Upper writedata bits are legitimately ignored for narrow configurations.
  assign unused_bits = ^writedata;

  // Register file, watchdog counter and prescaler. The output register
  // priority is: explicit write first, then the expiry mask.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
      automask <= '0;
      timeout  <= '0;
      count    <= '0;
      presc    <= '0;
      expired  <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (wr_data)
        data_reg <= writedata[DATA_WIDTH-1:0];
      else if (wr_set)
        data_reg <= data_reg | writedata[DATA_WIDTH-1:0];
      else if (wr_clear)
        data_reg <= data_reg & ~writedata[DATA_WIDTH-1:0];
      else if (expire)
        data_reg <= data_reg & ~automask;

      if (kick) begin
        count <= timeout;
        presc <= PRE_RELOAD;
      end else if (timeout_zero) begin
        count <= '0;
        presc <= '0;
      end else if (running) begin
        if (tick) begin
          count <= count - TIMER_WIDTH'(1);
          presc <= PRE_RELOAD;
        end else begin
          presc <= presc - PW'(1);
        end
      end

      if (wr_timeout)
        timeout <= writedata[TIMER_WIDTH-1:0];
      if (wr_automask)
        automask <= writedata[DATA_WIDTH-1:0];
      if (wr_status)
        irq_en <= writedata[2];

      // An expiry beats a simultaneous write-1-to-clear.
      if (expire)
        expired <= 1'b1;
      else if (wr_status && writedata[1])
        expired <= 1'b0;
    end
  end

  // Zero-latency read mux; unmapped addresses and write-only registers read 0.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data_reg);
      3'd3:    readdata = 32'(timeout);
      3'd4:    readdata = 32'(automask);
      3'd5:    readdata = {29'd0, irq_en, expired, running};
      3'd6:    readdata = 32'(count);
      default: readdata = '0;
    endcase
  end

  assign out_port = data_reg;

endmodule

// File: tb/tb_nios_system_timed_out_pio.sv
// tb_nios_system_timed_out_pio
//
// Directed bench for nios_system_timed_out_pio with PRESCALE=1 so that the
// counter moves once per clock. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_nios_system_timed_out_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int compared;
  int mismatched;

  nios_system_timed_out_pio #(
    .DATA_WIDTH (8),
    .TIMER_WIDTH(24),
    .PRESCALE   (1),
    .RESET_VALUE(8'h5A)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One write cycle; called on a falling edge, returns on the next one.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] wdata);
    address    = addr;
    writedata  = wdata;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Combinational read, no clock edge involved.
  task automatic readCheck(input string tag, input logic [2:0] addr,
                           input logic [31:0] expected);
    address = addr;
    #1;
    checkOutput(tag, readdata, expected);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset_out_port", {24'd0, out_port}, 32'h5A);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    readCheck("reset_data", 3'd0, 32'h5A);
    readCheck("reset_timeout", 3'd3, 32'd0);
    readCheck("reset_status", 3'd5, 32'd0);
    readCheck("reset_count", 3'd6, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // DATA write and readback
    applyStimulus(3'd0, 32'h0000_00A5);
    checkOutput("data_a5", {24'd0, out_port}, 32'hA5);
    readCheck("read_addr0", 3'd0, 32'h0000_00A5);
    readCheck("read_addr1", 3'd1, 32'd0);

    // SET then CLEAR
    applyStimulus(3'd0, 32'h0000_000F);
    applyStimulus(3'd1, 32'h0000_00F0);
    checkOutput("set_f0", {24'd0, out_port}, 32'hFF);
    applyStimulus(3'd2, 32'h0000_0081);
    checkOutput("clear_81", {24'd0, out_port}, 32'h7E);
    readCheck("read_addr2", 3'd2, 32'd0);

    // Address 7 ignores writes and reads 0
    applyStimulus(3'd7, 32'hFFFF_FFFF);
    checkOutput("addr7_no_effect", {24'd0, out_port}, 32'h7E);
    readCheck("read_addr7", 3'd7, 32'd0);

    // Expiry after exactly TIMEOUT cycles
    applyStimulus(3'd3, 32'd5);
    readCheck("timeout_rb", 3'd3, 32'd5);
    readCheck("timeout_no_start", 3'd5, 32'd0);
    applyStimulus(3'd4, 32'h01);
    readCheck("automask_rb", 3'd4, 32'h01);
    applyStimulus(3'd5, 32'h4);
    readCheck("irq_en_rb", 3'd5, 32'h4);
    applyStimulus(3'd0, 32'h03);
    readCheck("count_kick", 3'd6, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      readCheck($sformatf("count_step%0d", i), 3'd6, 32'(5 - i));
      checkOutput($sformatf("out_step%0d", i), {24'd0, out_port},
                  (i == 5) ? 32'h02 : 32'h03);
      checkOutput($sformatf("irq_step%0d", i), {31'd0, irq},
                  (i == 5) ? 32'd1 : 32'd0);
    end
    readCheck("status_expired", 3'd5, 32'h6);

    // Kick in the expiry cycle wins
    applyStimulus(3'd5, 32'h6);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    applyStimulus(3'd0, 32'h03);
    repeat (4) @(negedge clk);
    readCheck("count_before_kick", 3'd6, 32'd1);
    applyStimulus(3'd1, 32'h00);
    checkOutput("kick_out_port", {24'd0, out_port}, 32'h03);
    readCheck("kick_count", 3'd6, 32'd5);
    readCheck("kick_status", 3'd5, 32'h5);

    // TIMEOUT=0 mid-count stops the counter with no expiry
    repeat (2) @(negedge clk);
    readCheck("count_mid", 3'd6, 32'd3);
    applyStimulus(3'd3, 32'd0);
    readCheck("stop_status", 3'd5, 32'h4);
    repeat (8) @(negedge clk);
    checkOutput("stop_out_port", {24'd0, out_port}, 32'h03);
    checkOutput("stop_irq", {31'd0, irq}, 32'd0);
    readCheck("stop_status_later", 3'd5, 32'h4);

    // EXPIRED clear concurrent with expiry leaves EXPIRED set
    applyStimulus(3'd3, 32'd5);
    applyStimulus(3'd0, 32'h03);
    repeat (4) @(negedge clk);
    applyStimulus(3'd5, 32'h6);
    readCheck("clear_vs_expiry", 3'd5, 32'h6);
    checkOutput("clear_vs_expiry_out", {24'd0, out_port}, 32'h02);
    checkOutput("clear_vs_expiry_irq", {31'd0, irq}, 32'd1);

    // Reset in mid-count aborts without expiry
    applyStimulus(3'd5, 32'h6);
    applyStimulus(3'd0, 32'h03);
    repeat (3) @(negedge clk);
    readCheck("count_at_2", 3'd6, 32'd2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midreset_out", {24'd0, out_port}, 32'h5A);
    checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
    readCheck("midreset_count", 3'd6, 32'd0);
    readCheck("midreset_timeout", 3'd3, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("postreset_out", {24'd0, out_port}, 32'h5A);
    checkOutput("postreset_irq", {31'd0, irq}, 32'd0);
    readCheck("postreset_status", 3'd5, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
